// File: rtl/run_sequencer_if.sv
// run_sequencer_if: host start/done pins and core PC/run-enable controls for run_sequencer.
// The slave modport is the sequencer; the master modport is the host/core side.
interface run_sequencer_if #(
    parameter int PC_W = 10
);
    logic            start;
    logic            core_halt;
    logic            pc_load;
    logic [PC_W-1:0] pc_load_val;
    logic            core_run;
    logic            done;
    logic            busy;
    logic            timeout;
    logic [1:0]      prog_idx;
    logic [31:0]     cycle_count;
    modport master (
        output start, core_halt,
        input  pc_load, pc_load_val, core_run, done, busy, timeout, prog_idx, cycle_count
    );
    modport slave (
        input  start, core_halt,
        output pc_load, pc_load_val, core_run, done, busy, timeout, prog_idx, cycle_count
    );
endinterface

// File: rtl/run_sequencer.sv
// run_sequencer: launches the three resident programs in turn, with watchdog-forced completion.
// Optional RUN_SEQ_CYCLE_COUNT_EN builds the RUN-cycle counter reported on cycle_count.
module run_sequencer #(
    parameter int PC_W       = 10,
    parameter int PROG0_BASE = 0,
    parameter int PROG1_BASE = 256,
    parameter int PROG2_BASE = 512,
    parameter int WDT_W      = 16,
    parameter int WDT_LIMIT  = 50000
) (
    input logic clk,
    input logic rst_n,
    run_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARM, RUN, FIN} state_t;
    localparam logic [PC_W-1:0]  B0 = PC_W'(PROG0_BASE);
    localparam logic [PC_W-1:0]  B1 = PC_W'(PROG1_BASE);
    localparam logic [PC_W-1:0]  B2 = PC_W'(PROG2_BASE);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_LIMIT - 1);
    state_t           state_q, state_d;
    logic             start_q;
    logic [1:0]       prog_q, prog_d;
    logic [WDT_W-1:0] wdt_q, wdt_d;
    logic             timeout_q, timeout_d;
    always_comb begin
        state_d   = state_q;
        prog_d    = prog_q;
        wdt_d     = wdt_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: state_d = (start_q && !bus.start) ? ARM : IDLE;
            ARM: begin
                state_d   = RUN;
                wdt_d     = '0;
                timeout_d = 1'b0;
            end
            RUN: begin
                wdt_d = wdt_q + 1'b1;
                // host abort beats halt; halt beats watchdog expiry
                if (bus.start) begin
                    state_d = IDLE;
                end else if (bus.core_halt) begin
                    state_d = FIN;
                end else if (wdt_q == WDT_LAST) begin
                    state_d   = FIN;
                    timeout_d = 1'b1;
                end
            end
            FIN: begin
                if (bus.start) begin
                    state_d = IDLE;
                    prog_d  = (prog_q == 2'd2) ? 2'd0 : prog_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            start_q   <= 1'b0;
            prog_q    <= 2'd0;
            wdt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= bus.start;
            prog_q    <= prog_d;
            wdt_q     <= wdt_d;
            timeout_q <= timeout_d;
        end
    end
    assign bus.pc_load     = state_q == ARM;
    assign bus.core_run    = state_q == RUN;
    assign bus.done        = state_q == FIN;
    assign bus.busy        = state_q == ARM || state_q == RUN;
    assign bus.timeout     = timeout_q;
    assign bus.prog_idx    = prog_q;
    assign bus.pc_load_val = prog_q == 2'd1 ? B1 : prog_q == 2'd2 ? B2 : B0;
`ifdef RUN_SEQ_CYCLE_COUNT_EN
    logic [31:0] cnt_q, cnt_d, cnt_inc, cyc_q, cyc_d;
    always_comb begin
        cnt_inc = &cnt_q ? cnt_q : cnt_q + 32'd1;
        cnt_d   = state_q == ARM ? '0 : state_q == RUN ? cnt_inc : cnt_q;
        // the halting cycle itself is counted
        cyc_d   = (state_q == RUN && state_d == FIN) ? cnt_inc : cyc_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            cyc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            cyc_q <= cyc_d;
        end
    end
    assign bus.cycle_count = cyc_q;
`else
    assign bus.cycle_count = '0;
`endif
endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: randomized run/halt/abort stimulus against a run-level reference model,
// with a negedge monitor popping expected pc_load and done events from scoreboard queues.
module tb_run_sequencer;
    localparam int LIM = 40;
`ifdef RUN_SEQ_CYCLE_COUNT_EN
    localparam bit CC_EN = 1'b1;
`else
    localparam bit CC_EN = 1'b0;
`endif
    typedef struct {int pc; int cyc; logic to; int cc;} pc_exp_t;
    typedef struct {logic to; int len; int prog; int cc;} done_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    run_sequencer_if #(.PC_W(10)) bus ();
    run_sequencer #(
        .PC_W(10), .PROG0_BASE(0), .PROG1_BASE(256), .PROG2_BASE(512),
        .WDT_W(16), .WDT_LIMIT(LIM)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    pc_exp_t   pc_q[$];
    done_exp_t done_q[$];
    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    int prog_m = 0, cc_m = 0;
    logic to_m = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic int base(input int p);
        return p == 0 ? 0 : p == 1 ? 256 : 512;
    endfunction

    // h: RUN cycle carrying core_halt (>LIM means never); a: RUN cycle with start=1 (0 = none)
    task automatic launch_run(input int h, input int a);
        int last, stop;
        stop = (h < LIM) ? h : LIM;
        if (a >= stop) a = 0;
        pc_q.push_back('{base(prog_m), cyc + 1, to_m, cc_m});
        bus.start = 1'b0;
        to_m = 1'b0;
        step;
        bus.core_halt = 1'($urandom_range(0, 1));
        last = 0;
        for (int j = 1; j <= LIM; j++) begin
            step;
            bus.core_halt = (j == h);
            bus.start = (j == a);
            if (j == a || j == h || j == LIM) begin
                last = j;
                break;
            end
        end
        if (a == 0) begin
            to_m = h > LIM;
            cc_m = CC_EN ? last : 0;
            done_q.push_back('{to_m, last, prog_m, cc_m});
        end
        step;
        bus.core_halt = 1'b0;
        if (a == 0) begin
            repeat ($urandom_range(0, 3)) step;
            bus.start = 1'b1;
            step;
            prog_m = (prog_m + 1) % 3;
            repeat ($urandom_range(0, 2)) step;
        end
    endtask

    initial begin : monitor
        int run_cnt;
        logic done_prev, run_prev, ld_prev;
        pc_exp_t pe;
        done_exp_t de;
        run_cnt = 0;
        done_prev = 1'b0;
        run_prev = 1'b0;
        ld_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                run_cnt = 0;
                done_prev = 1'b0;
                run_prev = 1'b0;
                ld_prev = 1'b0;
            end else begin
                chk("done_excl", 32'(bus.done & (bus.busy | bus.core_run)), 0);
                if (ld_prev) chk("timeout_clr_arm", 32'(bus.timeout), 0);
                if (bus.pc_load) begin
                    if (pc_q.size() == 0) begin
                        chk("unexpected_pc_load", 1, 0);
                    end else begin
                        pe = pc_q.pop_front();
                        chk("pc_load_val", 32'(bus.pc_load_val), pe.pc);
                        chk("pc_load_latency", cyc, pe.cyc);
                        chk("timeout_sticky", 32'(bus.timeout), 32'(pe.to));
                        chk("cycle_count_held", bus.cycle_count, pe.cc);
                        chk("busy_arm", 32'(bus.busy), 1);
                    end
                    run_cnt = 0;
                end
                if (bus.core_run) run_cnt++;
                if (bus.done && !done_prev) begin
                    if (done_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        de = done_q.pop_front();
                        chk("done_timeout", 32'(bus.timeout), 32'(de.to));
                        chk("run_length", run_cnt, de.len);
                        chk("done_prog_idx", 32'(bus.prog_idx), de.prog);
                        chk("cycle_count", bus.cycle_count, de.cc);
                        chk("done_after_run", 32'(run_prev), 1);
                    end
                end
                done_prev = bus.done;
                run_prev = bus.core_run;
                ld_prev = bus.pc_load;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0;
        bus.core_halt = 1'b0;
        rst_n = 1'b0;
        repeat (3) step;
        rst_n = 1'b1;
        repeat (5) step;
        chk("rst_pc_load", 32'(bus.pc_load), 0);
        chk("rst_pc_load_val", 32'(bus.pc_load_val), 0);
        chk("rst_core_run", 32'(bus.core_run), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_timeout", 32'(bus.timeout), 0);
        chk("rst_prog_idx", 32'(bus.prog_idx), 0);
        chk("rst_cycle_count", bus.cycle_count, 0);
        bus.start = 1'b1;
        repeat (3) step;
        launch_run(20, 0);
        launch_run(37, 0);
        launch_run(LIM, 0);
        launch_run(1000, 0);
        launch_run(1000, 5);
        launch_run(3, 0);
        launch_run(2, 0);
        // reset in the middle of a run
        pc_q.push_back('{base(prog_m), cyc + 1, to_m, cc_m});
        bus.start = 1'b0;
        repeat (4) step;
        rst_n = 1'b0;
        step;
        chk("midrst_core_run", 32'(bus.core_run), 0);
        chk("midrst_prog_idx", 32'(bus.prog_idx), 0);
        chk("midrst_timeout", 32'(bus.timeout), 0);
        chk("midrst_cycle_count", bus.cycle_count, 0);
        prog_m = 0;
        to_m = 1'b0;
        cc_m = 0;
        rst_n = 1'b1;
        bus.start = 1'b1;
        step;
        for (int r = 0; r < 25; r++) begin
            if ($urandom_range(0, 9) < 2) launch_run(1000, $urandom_range(1, LIM - 1));
            else launch_run($urandom_range(1, LIM + 5), 0);
        end
        repeat (5) step;
        chk("pc_queue_empty", pc_q.size(), 0);
        chk("done_queue_empty", done_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
